sp_ram_pipelined: RTL and testbench

//   Parametrised single-port RAM with a valid/ready request port, byte-enable writes,

---
 rtl/sp_ram_pkg.sv | 12 +
 rtl/sp_ram_rsp_fifo.sv | 72 +++++++
 rtl/sp_ram_pipelined.sv | 142 ++++++++++++++
 tb/tb_sp_ram_pipelined.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the pipelined single-port scratch RAM.
package sp_ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int MAX_RD_LAT = 2;
    localparam int BYTE_W     = 8;

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// In-order read-response buffer; head word, empty and full are all registered outputs.
module sp_ram_rsp_fifo
    import sp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH_F = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
    localparam int CNT_W = $clog2(DEPTH_F + 1);

    logic [DATA_W-1:0] buf_q [DEPTH_F];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              empty_q, full_q;
    logic              do_push, do_pop;

    // Depth may be 3, so pointers wrap explicitly rather than by overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH_F - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        // A word pushed into the slot that becomes the head bypasses storage.
        head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : buf_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CNT_W'(DEPTH_F));
        end
    end

    assign head_data = head_q;
    assign empty     = empty_q;
    assign full      = full_q;

endmodule

// File: rtl/sp_ram_pipelined.sv
// Pipelined single-port scratch RAM: byte-enable writes, in-order read responses
// with credit-limited back-pressure and an optional post-reset zero-fill sweep.
module sp_ram_pipelined
    import sp_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/BYTE_W-1:0] req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     init_done
);

    localparam int NB     = DATA_W / BYTE_W;
    localparam int FIFO_D = RD_LAT + 1;
    localparam int OUT_W  = $clog2(RD_LAT + 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic              init_we;
    logic              req_ready_q, init_done_q;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic              addr_ok, wr_acc, rd_acc, pop;
    logic [DATA_W-1:0] rd_word, rd_data;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              fifo_empty, fifo_full;

    assign addr_ok = 32'(req_addr) < DEPTH;
    assign wr_acc  = req_valid && req_ready_q && req_we;
    assign rd_acc  = req_valid && req_ready_q && !req_we;
    assign pop     = !fifo_empty && rsp_ready;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_we     = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    init_addr_d = init_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Credits count reads anywhere between accept and pop, so the FIFO never overflows.
    assign outstanding_d = outstanding_q + OUT_W'(rd_acc) - OUT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            init_addr_q   <= '0;
            outstanding_q <= '0;
            req_ready_q   <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_addr_q   <= init_addr_d;
            outstanding_q <= outstanding_d;
            req_ready_q   <= (state_d == ST_RUN) && (outstanding_d < OUT_W'(RD_LAT + 1));
            init_done_q   <= (state_d == ST_RUN);
        end
    end

    // One storage array per byte lane keeps byte-enable writes single-driver.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [BYTE_W-1:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (init_we) begin
                lane_mem[init_addr_q] <= '0;
            end else if (wr_acc && addr_ok && req_be[gi]) begin
                lane_mem[req_addr] <= req_wdata[gi*BYTE_W +: BYTE_W];
            end
        end

        assign rd_word[gi*BYTE_W +: BYTE_W] = lane_mem[req_addr];
    end

    assign rd_data = addr_ok ? rd_word : '0;

    // The FIFO entry is the final read register, so RD_LAT-1 extra stages sit in front of it.
    if (RD_LAT < MAX_RD_LAT) begin : g_lat_direct
        assign push      = rd_acc;
        assign push_data = rd_data;
    end else begin : g_lat_pipe
        logic              pipe_v_q;
        logic [DATA_W-1:0] pipe_d_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_v_q <= 1'b0;
                pipe_d_q <= '0;
            end else begin
                pipe_v_q <= rd_acc;
                pipe_d_q <= rd_data;
            end
        end

        assign push      = pipe_v_q;
        assign push_data = pipe_d_q;
    end

    sp_ram_rsp_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH_F (FIFO_D)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (rsp_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    credit_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && push && !pop));

    assign req_ready = req_ready_q;
    assign rsp_valid = !fifo_empty;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sp_ram_pipelined.sv
// Two RAM instances (8-bit/64/lat1 and 32-bit/48/lat2) checked every cycle against a behavioural model.
module tb_sp_ram_pipelined;

    localparam int D0 = 64, W0 = 8,  L0 = 1;
    localparam int D1 = 48, W1 = 32, L1 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_we, rsp_ready;
    logic [1:0]  req_ready, rsp_valid, init_done;
    logic [5:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic [7:0]  rdata0;
    logic [31:0] rdata1;

    int nvec = 0;
    int nmis = 0;

    // Behavioural model: memory image, response queue (ring) with due cycle, cycle counters.
    logic [31:0] mmem [2][64];
    logic [31:0] qd   [2][4];
    int          qt   [2][4];
    int          qh   [2];
    int          qn   [2];
    int          cyc   = 0;
    int          since = 0;

    always #5 clk = ~clk;

    sp_ram_pipelined #(.DATA_W(W0), .DEPTH(D0), .RD_LAT(L0), .INIT_ZERO(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0][7:0]), .req_be(req_be[0][0:0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rdata0),
        .init_done(init_done[0])
    );

    sp_ram_pipelined #(.DATA_W(W1), .DEPTH(D1), .RD_LAT(L1), .INIT_ZERO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rdata1),
        .init_done(init_done[1])
    );

    function automatic int dep(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? L0 : L1;
    endfunction

    function automatic logic [31:0] wmask(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rdata(input int k);
        return (k == 0) ? {24'h0, rdata0} : rdata1;
    endfunction

    function automatic logic m_valid(input int k);
        return (qn[k] > 0) && (qt[k][qh[k]] <= cyc);
    endfunction

    function automatic logic m_ready(input int k);
        return (since >= dep(k)) && (qn[k] < lat(k) + 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            qh[k] = 0;
            qn[k] = 0;
            for (int a = 0; a < 64; a++) mmem[k][a] = 32'h0;
        end
        since = 0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic acc, popm;
            int   a;
            acc  = req_valid[k] && m_ready(k);
            popm = m_valid(k) && rsp_ready[k];
            a    = int'(req_addr[k]);
            if (popm) begin
                qh[k] = (qh[k] + 1) % 4;
                qn[k] = qn[k] - 1;
            end
            if (acc && !req_we[k]) begin
                qd[k][(qh[k] + qn[k]) % 4] = (a < dep(k)) ? mmem[k][a] : 32'h0;
                qt[k][(qh[k] + qn[k]) % 4] = cyc + lat(k);
                qn[k] = qn[k] + 1;
            end
            if (acc && req_we[k] && (a < dep(k))) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[k][b]) mmem[k][a][8*b +: 8] = req_wdata[k][8*b +: 8];
                mmem[k][a] = mmem[k][a] & wmask(k);
            end
        end
        since++;
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    chk($sformatf("rst_rsp_valid%0d", k), {31'h0, rsp_valid[k]}, 32'h0);
                    chk($sformatf("rst_req_ready%0d", k), {31'h0, req_ready[k]}, 32'h0);
                    chk($sformatf("rst_init_done%0d", k), {31'h0, init_done[k]}, 32'h0);
                end else begin
                    chk($sformatf("req_ready%0d", k), {31'h0, req_ready[k]}, {31'h0, m_ready(k)});
                    chk($sformatf("init_done%0d", k), {31'h0, init_done[k]},
                        {31'h0, since >= dep(k)});
                    chk($sformatf("rsp_valid%0d", k), {31'h0, rsp_valid[k]}, {31'h0, m_valid(k)});
                    if (m_valid(k))
                        chk($sformatf("rsp_rdata%0d", k), rdata(k), qd[k][qh[k]]);
                end
            end
        end
    end

    // All directed tasks start and end at 1 time unit after a rising edge.
    task automatic wait_acc(input int k, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[k] && n < 200) begin
            n++;
            @(negedge clk);
        end
        t = cyc;
        if (!req_ready[k]) begin
            nvec++;
            nmis++;
            $display("FAIL accept_timeout%0d: req_ready stayed 0, expected 1 within 200 cycles", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int k, input int a, input logic [31:0] d, input logic [3:0] be);
        int t;
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b1;
        req_addr[k]  = 6'(a);
        req_wdata[k] = d;
        req_be[k]    = be;
        wait_acc(k, t);
        req_valid[k] = 1'b0;
        $display("write inst%0d addr %0d data %h be %h (cycle %0d)", k, a, d, be, t);
    endtask

    task automatic do_read(input int k, input int a, input logic [31:0] exp, input int exp_lat);
        int t0, n;
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b0;
        req_addr[k]  = 6'(a);
        wait_acc(k, t0);
        req_valid[k] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[k] && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("read%0d_a%0d", k, a), rdata(k), exp);
        chk($sformatf("read%0d_lat", k), 32'(cyc - t0), 32'(exp_lat));
        $display("read  inst%0d addr %0d data %h latency %0d", k, a, rdata(k), cyc - t0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input int e0, input int e1);
        int n0, n1, n;
        n0 = 0; n1 = 0; n = 0;
        while ((!req_ready[0] || !req_ready[1]) && n < 300) begin
            @(negedge clk);
            if (!req_ready[0]) n0++;
            if (!req_ready[1]) n1++;
            n++;
        end
        chk("init_cycles0", 32'(n0), 32'(e0));
        chk("init_cycles1", 32'(n1), 32'(e1));
        chk("init_done_lit0", {31'h0, init_done[0]}, 32'h1);
        chk("init_done_lit1", {31'h0, init_done[1]}, 32'h1);
        $display("init sweep: inst0 %0d cycles, inst1 %0d cycles", n0, n1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got, n;
        logic acc3;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_be[k]    = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata0", {24'h0, rdata0}, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        rst_n = 1'b1;
        wait_init(64, 48);

        // Zero-filled contents at the low, middle and top addresses.
        do_read(0, 0, 32'h0, 1);
        do_read(0, 31, 32'h0, 1);
        do_read(0, 63, 32'h0, 1);
        do_read(1, 0, 32'h0, 2);
        do_read(1, 47, 32'h0, 2);

        // Read-after-write and a no-op byte-enable write.
        do_write(0, 5, 32'hA5, 4'h1);
        do_read(0, 5, 32'hA5, 1);
        do_write(0, 5, 32'h3C, 4'h0);
        do_read(0, 5, 32'hA5, 1);

        // Partial byte-enable merge on the 32-bit instance.
        do_write(1, 7, 32'h1122_3344, 4'hF);
        do_write(1, 7, 32'hAABB_CCDD, 4'b0101);
        do_read(1, 7, 32'h11BB_33DD, 2);

        // Out-of-range address on the 48-deep instance.
        do_write(1, 47, 32'hCAFE_F00D, 4'hF);
        do_write(1, 50, 32'hFFFF_FFFF, 4'hF);
        do_read(1, 50, 32'h0, 2);
        do_read(1, 47, 32'hCAFE_F00D, 2);

        // Back-to-back reads at one per cycle on the latency-1 instance.
        for (int i = 0; i < 4; i++) do_write(0, 10 + i, 32'h50 + 32'(i), 4'h1);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr[0] = 6'(10 + i);
            @(negedge clk);
            chk("b2b_ready", {31'h0, req_ready[0]}, 32'h1);
            $display("b2b   inst0 addr %0d issued", 10 + i);
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure: three credits with latency 2, fourth read waits for a pop.
        for (int i = 0; i < 4; i++) do_write(1, i, 32'hD0D0_0000 + 32'(i), 4'hF);
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr[1] = 6'(i);
            @(negedge clk);
            chk("bp_accept", {31'h0, req_ready[1]}, 32'h1);
            @(posedge clk);
            #1;
        end
        req_addr[1] = 6'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_blocked", {31'h0, req_ready[1]}, 32'h0);
            chk("bp_hold_valid", {31'h0, rsp_valid[1]}, 32'h1);
            chk("bp_hold_data", rdata1, 32'hD0D0_0000);
            @(posedge clk);
            #1;
        end
        rsp_ready[1] = 1'b1;
        got = 0; n = 0; acc3 = 1'b0;
        while (got < 4 && n < 30) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                chk($sformatf("bp_order%0d", got), rdata1, 32'hD0D0_0000 + 32'(got));
                $display("pop   inst1 #%0d data %h", got, rdata1);
                got++;
            end
            if (req_valid[1] && req_ready[1]) acc3 = 1'b1;
            @(posedge clk);
            #1;
            if (acc3) req_valid[1] = 1'b0;
            n++;
        end
        chk("bp_count", 32'(got), 32'd4);
        chk("bp_rd3_accepted", {31'h0, acc3}, 32'h1);
        repeat (3) @(posedge clk);
        #1;

        // Reset with two reads in flight.
        do_write(1, 20, 32'h1234_5678, 4'hF);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 6'd20;
        @(posedge clk);
        #1;
        req_addr[1]  = 6'd21;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        chk("pre_reset_valid", {31'h0, rsp_valid[1]}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
        chk("async_req_ready", {31'h0, req_ready[1]}, 32'h0);
        $display("reset asserted with reads in flight (cycle %0d)", cyc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init(64, 48);
        do_read(1, 20, 32'h0, 2);
        do_read(0, 5, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        nmis++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
